// File: rtl/router_pkg.sv
// Shared router types and sizing used by the switch allocator and its arbiters.
package router_pkg;

    localparam int NUM_PORTS        = 5;
    localparam int NUM_VCS          = 4;
    localparam int CREDIT_CTR_WIDTH = 3;
    localparam int VC_ID_BITS       = $clog2(NUM_VCS);
    localparam int PORT_BITS        = $clog2(NUM_PORTS);

    // Output direction; the numeric value doubles as the output port index.
    typedef enum logic [2:0] {
        DIR_N = 3'd0,
        DIR_E = 3'd1,
        DIR_S = 3'd2,
        DIR_W = 3'd3,
        DIR_R = 3'd4,
        DI    = 3'd7
    } dir_t;

    typedef struct packed {
        logic                  valid;
        logic [PORT_BITS-1:0]  in_port;
        logic [VC_ID_BITS-1:0] in_vc;
    } sa_grant_t;

    // Explicit wrap so a non-power-of-two port count never relies on truncation.
    function automatic logic [PORT_BITS-1:0] next_port(input logic [PORT_BITS-1:0] p);
        return (p == PORT_BITS'(NUM_PORTS - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [VC_ID_BITS-1:0] next_vc(input logic [VC_ID_BITS-1:0] v);
        return (v == VC_ID_BITS'(NUM_VCS - 1)) ? '0 : v + 1'b1;
    endfunction

endpackage

// File: rtl/switch_allocator_rr_if.sv
// Request/credit inputs and grant/crossbar outputs of the switch allocator.
interface switch_allocator_rr_if
    import router_pkg::*;
;
    dir_t [NUM_PORTS-1:0][NUM_VCS-1:0]                              req_out_dir_sa;
    logic [NUM_PORTS-1:0][NUM_VCS-1:0][VC_ID_BITS-1:0]              out_vc_id;
    logic [NUM_PORTS-1:0][NUM_VCS-1:0][CREDIT_CTR_WIDTH-1:0]        ovc_credits_count_r;
    logic [NUM_PORTS-1:0][NUM_VCS-1:0]                              sw_allocated_r;
    logic [NUM_PORTS-1:0][PORT_BITS-1:0]                            xbar_sel_r;
    logic [NUM_PORTS-1:0]                                           xbar_valid_r;
    logic [NUM_PORTS-1:0][NUM_VCS-1:0]                              credit_consume;

    modport master (
        output req_out_dir_sa, out_vc_id, ovc_credits_count_r,
        input  sw_allocated_r, xbar_sel_r, xbar_valid_r, credit_consume
    );

    modport slave (
        input  req_out_dir_sa, out_vc_id, ovc_credits_count_r,
        output sw_allocated_r, xbar_sel_r, xbar_valid_r, credit_consume
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_onehot_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          any_o
);

    int idx;

    always_comb begin
        gnt_onehot_o = '0;
        gnt_idx_o    = '0;
        any_o        = 1'b0;
        idx          = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_o && req_i[idx]) begin
                any_o             = 1'b1;
                gnt_idx_o         = IW'(idx);
                gnt_onehot_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_allocator_rr.sv
// Separable input-first round-robin switch allocator with iSLIP pointer updates.
module switch_allocator_rr
    import router_pkg::*;
(
    input  logic                 clk,
    input  logic                 arst_n,
    switch_allocator_rr_if.slave sa
);

    logic [NUM_PORTS-1:0][NUM_VCS-1:0]    sw_alloc_q, sw_alloc_d;
    logic [NUM_PORTS-1:0][NUM_VCS-1:0]    pend_q, pend_d;
    logic [NUM_PORTS-1:0][NUM_VCS-1:0]    eligible;
    logic [NUM_PORTS-1:0][PORT_BITS-1:0]  xbar_sel_q, xbar_sel_d;
    logic [NUM_PORTS-1:0][PORT_BITS-1:0]  out_ptr_q, out_ptr_d;
    logic [NUM_PORTS-1:0]                 xbar_valid_q, xbar_valid_d;
    logic [NUM_PORTS-1:0][VC_ID_BITS-1:0] in_ptr_q, in_ptr_d;

    logic [NUM_PORTS-1:0][NUM_VCS-1:0]    s1_onehot;
    logic [NUM_PORTS-1:0][VC_ID_BITS-1:0] s1_idx;
    logic [NUM_PORTS-1:0]                 s1_any;
    logic [NUM_PORTS-1:0][PORT_BITS-1:0]  s1_dir;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]  s2_req, s2_onehot;
    logic [NUM_PORTS-1:0][PORT_BITS-1:0]  s2_idx;
    logic [NUM_PORTS-1:0]                 s2_any;
    logic [NUM_PORTS-1:0]                 in_won;
    sa_grant_t [NUM_PORTS-1:0]            grant;
    logic [NUM_PORTS-1:0][VC_ID_BITS-1:0] grant_ovc;

    // pend_q holds last cycle's grants, standing in for the not-yet-decremented credit.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_elig
        for (genvar gv = 0; gv < NUM_VCS; gv++) begin : g_vc
            logic [PORT_BITS-1:0]  dp;
            logic [VC_ID_BITS-1:0] o;
            assign dp = sa.req_out_dir_sa[gi][gv];
            assign o  = sa.out_vc_id[gi][gv];
            assign eligible[gi][gv] = (int'(dp) < NUM_PORTS) && (int'(dp) != gi) &&
                (sa.ovc_credits_count_r[dp][o] >
                 {{(CREDIT_CTR_WIDTH-1){1'b0}}, pend_q[dp][o]});
        end
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_stage1
        rr_arbiter #(.N(NUM_VCS)) u_in_arb (
            .req_i        (eligible[gi]),
            .ptr_i        (in_ptr_q[gi]),
            .gnt_onehot_o (s1_onehot[gi]),
            .gnt_idx_o    (s1_idx[gi]),
            .any_o        (s1_any[gi])
        );
        assign s1_dir[gi] = sa.req_out_dir_sa[gi][s1_idx[gi]];
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_stage2
        for (genvar gj = 0; gj < NUM_PORTS; gj++) begin : g_req
            assign s2_req[gi][gj] = s1_any[gj] && (s1_dir[gj] == PORT_BITS'(gi));
        end
        rr_arbiter #(.N(NUM_PORTS)) u_out_arb (
            .req_i        (s2_req[gi]),
            .ptr_i        (out_ptr_q[gi]),
            .gnt_onehot_o (s2_onehot[gi]),
            .gnt_idx_o    (s2_idx[gi]),
            .any_o        (s2_any[gi])
        );
        assign grant[gi].valid   = s2_any[gi];
        assign grant[gi].in_port = s2_idx[gi];
        assign grant[gi].in_vc   = s1_idx[s2_idx[gi]];
        assign grant_ovc[gi]     = sa.out_vc_id[grant[gi].in_port][grant[gi].in_vc];
        assign in_won[gi]        = s1_any[gi] && s2_onehot[s1_dir[gi]][gi];
    end

    always_comb begin
        sw_alloc_d   = '0;
        pend_d       = '0;
        xbar_valid_d = '0;
        xbar_sel_d   = xbar_sel_q;
        in_ptr_d     = in_ptr_q;
        out_ptr_d    = out_ptr_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (in_won[i]) begin
                sw_alloc_d[i] = s1_onehot[i];
                in_ptr_d[i]   = next_vc(s1_idx[i]);
            end
        end
        for (int d = 0; d < NUM_PORTS; d++) begin
            if (grant[d].valid) begin
                xbar_valid_d[d]         = 1'b1;
                xbar_sel_d[d]           = grant[d].in_port;
                out_ptr_d[d]            = next_port(grant[d].in_port);
                pend_d[d][grant_ovc[d]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sw_alloc_q   <= '0;
            pend_q       <= '0;
            xbar_valid_q <= '0;
            xbar_sel_q   <= '0;
            in_ptr_q     <= '0;
            out_ptr_q    <= '0;
        end else begin
            sw_alloc_q   <= sw_alloc_d;
            pend_q       <= pend_d;
            xbar_valid_q <= xbar_valid_d;
            xbar_sel_q   <= xbar_sel_d;
            in_ptr_q     <= in_ptr_d;
            out_ptr_q    <= out_ptr_d;
        end
    end

    assign sa.sw_allocated_r = sw_alloc_q;
    assign sa.xbar_sel_r     = xbar_sel_q;
    assign sa.xbar_valid_r   = xbar_valid_q;
    assign sa.credit_consume = pend_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (arst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                assert ($onehot0(sw_alloc_q[i]));
                assert ($onehot0(pend_q[i]));
                if (grant[i].valid) begin
                    assert (sa.ovc_credits_count_r[i][grant_ovc[i]] != '0);
                end
                for (int v = 0; v < NUM_VCS; v++) begin
                    assert (int'(sa.req_out_dir_sa[i][v]) != i)
                        else $warning("U-turn request ignored at input %0d vc %0d", i, v);
                end
            end
        end
    end
`endif

endmodule

// File: doc/switch_allocator_rr.md
Name: switch_allocator_rr

Overview:
- Separable, input-first, round-robin switch allocator for one router.
- Takes the per-VC switch requests produced by every input block (req_out_dir_sa) and downstream credit state.
- Each cycle, grants at most one VC per input port and at most one input port per output port.
- Drives each input block's sw_allocated_r and the crossbar select lines.

Parameters:
NUM_PORTS, 5, router ports (N,E,S,W,R); output index equals dir_t value
NUM_VCS, 4, virtual channels per port
CREDIT_CTR_WIDTH, 3, width of downstream credit counters
VC_ID_BITS, $clog2(NUM_VCS), VC index width
PORT_BITS, $clog2(NUM_PORTS), port index width

Ports:
clk  in  1  clock
arst_n  in  1  reset, asynchronous, active-low
req_out_dir_sa  in  dir_t [NUM_PORTS][NUM_VCS]  requested output direction per input VC; DI = no request
out_vc_id  in  VC_ID_BITS [NUM_PORTS][NUM_VCS]  downstream VC already allocated to each input VC
ovc_credits_count_r  in  CREDIT_CTR_WIDTH [NUM_PORTS][NUM_VCS]  free downstream slots per output VC
sw_allocated_r  out  1 [NUM_PORTS][NUM_VCS]  registered grant pulse per input VC
xbar_sel_r  out  PORT_BITS [NUM_PORTS]  input port driving each output
xbar_valid_r  out  1 [NUM_PORTS]  output carries a flit this cycle
credit_consume  out  1 [NUM_PORTS][NUM_VCS]  pulse with grant; decrements output-VC credit counter

Behaviour:
- Reset (arst_n low, asynchronous): all sw_allocated_r, xbar_valid_r and credit_consume = 0; xbar_sel_r = 0; all round-robin pointers = 0. Reset mid-operation drops any pending grant. First grant is possible on the second clk edge after deassertion.
- Latency: requests sampled in cycle t produce grants registered at edge t+1. All grant outputs are single-cycle pulses and are re-evaluated every cycle. No multi-cycle state beyond pointers and pending flags.
- Eligibility of input VC (i,v) with d = req_out_dir_sa[i][v] and o = out_vc_id[i][v]:
  - d != DI
  - d != i (U-turn). This is illegal: the request is ignored and flagged by an assertion in non-SYNTHESIS builds.
  - ovc_credits_count_r[d][o] > pend[d][o]
- pend[d][o] is 1 if a grant to (d,o) was registered in the previous cycle, else 0. It covers the one-cycle lag before the credit counter decrements.
- Stage 1 (per input i): round-robin over eligible VCs starting at in_ptr[i]. The winner becomes input i's single request toward its d.
- Stage 2 (per output d): round-robin over inputs whose stage-1 winner targets d, starting at out_ptr[d].
- Grant (i,v,d) sets at the next edge:
  - sw_allocated_r[i][v] = 1
  - xbar_sel_r[d] = i
  - xbar_valid_r[d] = 1
  - credit_consume[d][o] = 1
  - pend[d][o] = 1
- Pointer update (iSLIP rule), only on grant:
  - out_ptr[d] <= (i+1) mod NUM_PORTS
  - in_ptr[i] <= (v+1) mod NUM_VCS
  - An input whose stage-1 winner loses stage 2 keeps its pointer. This guarantees starvation freedom.
- Wrap-around: pointers at NUM_PORTS-1 / NUM_VCS-1 wrap to 0; non-power-of-two NUM_PORTS must wrap explicitly, not by truncation.
- Invariants, asserted in non-SYNTHESIS builds:
  - Per output: at most one input granted.
  - Per input: at most one VC granted.
  - A grant never occurs with zero credits.
- Simultaneous events:
  - A request whose credit reaches zero in the same cycle is not granted.
  - A credit return arriving with a pend entry is already reflected in ovc_credits_count_r; only the comparison with pend applies.
- Outputs with no grant: xbar_valid_r = 0, xbar_sel_r holds its previous value.

Decomposition:
- router_pkg holds NUM_PORTS, NUM_VCS, CREDIT_CTR_WIDTH, VC_ID_BITS, PORT_BITS and dir_t (incl. DI). It also gains a new typedef sa_grant_t {valid, in_port, in_vc}.
- One sub-module: rr_arbiter #(N). Inputs: req[N], ptr. Outputs: gnt_onehot, gnt_idx, any. It is purely combinational and instantiated NUM_PORTS times per stage.
- Pointer and pend registers live in switch_allocator_rr.

Test Plan:
- Single request: input N VC0 requests E, o=1, credits[E][1]=3. Response one cycle later: sw_allocated_r[N][0]=1, xbar_sel_r[E]=N, xbar_valid_r[E]=1, credit_consume[E][1]=1.
- Input VC fairness: input W VCs 0 and 2 both request S continuously with ample credits. Grants alternate VC0, VC2, VC0… and never both in one cycle.
- Output fairness: inputs N, S, R all request E continuously. Grants to E rotate N→S→R→N; each input gets 1/3 of cycles over 30 cycles.
- Credit gating: credits[E][1]=1, request held with the counter decremented after the grant. Exactly one grant, then none. After the credit is raised back to 1, one more grant follows.
- Zero credit / illegal: credits=0 → no grant for 10 cycles. A request with d equal to its own input port → no grant, assertion fires.
- Reset mid-operation: assert arst_n during an active grant cycle. All outputs 0 immediately (asynchronous), pointers 0. After release with the fairness scenario re-applied, the first winner is the lowest index.
